// File: rtl/mpu_frame_asm_pkg.sv
// Shared types and constants for the MPU6050 frame assembler.
// Burst layout: byte 2k is the MSB and byte 2k+1 the LSB of word k.
package mpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_REQ  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_ARMED     = 3'd3,
    ST_COLLECT   = 3'd4
  } mpu_state_e;

  localparam int MPU_BURST_BYTES = 14;
  localparam int MPU_WORDS       = MPU_BURST_BYTES / 2;

  // Word slots in the order the register burst delivers them.
  localparam int AX   = 0;
  localparam int AY   = 1;
  localparam int AZ   = 2;
  localparam int TEMP = 3;
  localparam int GX   = 4;
  localparam int GY   = 5;
  localparam int GZ   = 6;

  localparam logic [7:0] TICK_MISS_MAX = 8'hFF;

  function automatic logic [15:0] mpu_pack_word(input logic [7:0] msb,
                                                input logic [7:0] lsb);
    return {msb, lsb};
  endfunction

endpackage

// File: rtl/mpu_frame_asm_if.sv
// Signal bundle between the frame assembler and the I2C controller /
// attitude stage. master = assembler side, slave = environment side.
interface mpu_frame_asm_if;

  logic               enable;
  logic               init_done;
  logic               busy_now;
  logic               data_avalid;
  logic [7:0]         data;

  logic               mpu_init;
  logic               mpu_transfer;
  logic signed [15:0] ax;
  logic signed [15:0] ay;
  logic signed [15:0] az;
  logic signed [15:0] temp;
  logic signed [15:0] gx;
  logic signed [15:0] gy;
  logic signed [15:0] gz;
  logic               frame_valid;
  logic               frame_err;
  logic [7:0]         tick_miss;

  modport master (
    input  enable, init_done, busy_now, data_avalid, data,
    output mpu_init, mpu_transfer, ax, ay, az, temp, gx, gy, gz,
           frame_valid, frame_err, tick_miss
  );

  modport slave (
    output enable, init_done, busy_now, data_avalid, data,
    input  mpu_init, mpu_transfer, ax, ay, az, temp, gx, gy, gz,
           frame_valid, frame_err, tick_miss
  );

endinterface

// File: rtl/mpu_frame_asm_rate_tick.sv
// Sample-rate divider: one-cycle tick every PERIOD cycles while run is high.
// Dropping run clears the count so the next run restarts a full period.
module mpu_rate_tick #(
  parameter int unsigned PERIOD = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mpu_frame_asm.sv
// MPU6050 frame assembler: issues init once, then periodic burst reads, and
// packs each 14-byte burst into seven signed words published atomically.
//
// state        | meaning
// ST_IDLE      | disabled, rate divider held at zero
// ST_INIT_REQ  | waiting for controller idle to issue mpu_init
// ST_INIT_WAIT | init issued, waiting for init_done
// ST_ARMED     | waiting for the next sample tick
// ST_COLLECT   | burst in flight, gathering bytes under timeout
module mpu_frame_asm
  import mpu_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SAMPLE_HZ   = 500,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input logic             clk,
  input logic             rst_n,
  mpu_frame_asm_if.master bus
);

  localparam int unsigned TICK_RAW    = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TICK_PERIOD = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int unsigned TW          = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    LAST_IDX  = 4'(MPU_BURST_BYTES - 1);

  mpu_state_e    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    tick_miss_q, tick_miss_d;
  logic          mpu_init_q, mpu_init_d;
  logic          mpu_xfer_q, mpu_xfer_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;

  logic [7:0]    shadow_q [MPU_BURST_BYTES];
  logic [7:0]    burst    [MPU_BURST_BYTES];
  logic [15:0]   words_q  [MPU_WORDS];

  logic          shadow_we;
  logic          words_load;
  logic          miss_inc;
  logic          run;
  logic          tick;

  assign run = (state_q != ST_IDLE);

  mpu_rate_tick #(
    .PERIOD (TICK_PERIOD)
  ) u_rate_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    to_cnt_d      = to_cnt_q;
    tick_miss_d   = tick_miss_q;
    mpu_init_d    = 1'b0;
    mpu_xfer_d    = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    shadow_we     = 1'b0;
    words_load    = 1'b0;
    miss_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = bus.init_done ? ST_ARMED : ST_INIT_REQ;
        end
      end

      ST_INIT_REQ: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (!bus.busy_now) begin
          mpu_init_d = 1'b1;
          state_d    = ST_INIT_WAIT;
        end
      end

      ST_INIT_WAIT: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.init_done) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (bus.busy_now) begin
            miss_inc = 1'b1;
          end else begin
            mpu_xfer_d = 1'b1;
            idx_d      = '0;
            to_cnt_d   = TO_LOAD;
            state_d    = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        // Ticks during a burst are dropped, not queued; enable is only
        // honoured once the frame completes or aborts.
        if (tick) begin
          miss_inc = 1'b1;
        end
        if (bus.data_avalid) begin
          shadow_we = 1'b1;
          idx_d     = idx_q + 1'b1;
        end
        if (bus.data_avalid && (idx_q == LAST_IDX)) begin
          words_load    = 1'b1;
          frame_valid_d = 1'b1;
          state_d       = bus.enable ? ST_ARMED : ST_IDLE;
        end else if (to_cnt_q == '0) begin
          frame_err_d = 1'b1;
          state_d     = bus.enable ? ST_ARMED : ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (miss_inc && (tick_miss_q != TICK_MISS_MAX)) begin
      tick_miss_d = tick_miss_q + 8'd1;
    end
  end

  // The final byte bypasses the shadow so the words can update the cycle
  // after the 14th strobe.
  always_comb begin
    for (int i = 0; i < MPU_BURST_BYTES; i++) begin
      burst[i] = (shadow_we && (idx_q == 4'(i))) ? bus.data : shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      to_cnt_q      <= '0;
      tick_miss_q   <= '0;
      mpu_init_q    <= 1'b0;
      mpu_xfer_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      to_cnt_q      <= to_cnt_d;
      tick_miss_q   <= tick_miss_d;
      mpu_init_q    <= mpu_init_d;
      mpu_xfer_q    <= mpu_xfer_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MPU_BURST_BYTES; i++) begin
        shadow_q[i] <= '0;
      end
      for (int k = 0; k < MPU_WORDS; k++) begin
        words_q[k] <= '0;
      end
    end else begin
      for (int i = 0; i < MPU_BURST_BYTES; i++) begin
        shadow_q[i] <= burst[i];
      end
      if (words_load) begin
        for (int k = 0; k < MPU_WORDS; k++) begin
          words_q[k] <= mpu_pack_word(burst[2*k], burst[2*k+1]);
        end
      end
    end
  end

  assign bus.mpu_init     = mpu_init_q;
  assign bus.mpu_transfer = mpu_xfer_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.tick_miss    = tick_miss_q;
  assign bus.ax           = words_q[AX];
  assign bus.ay           = words_q[AY];
  assign bus.az           = words_q[AZ];
  assign bus.temp         = words_q[TEMP];
  assign bus.gx           = words_q[GX];
  assign bus.gy           = words_q[GY];
  assign bus.gz           = words_q[GZ];

endmodule

// File: doc/mpu_frame_asm.md
# mpu_frame_asm

Downstream consumer of the bit-banged MPU6050 I2C controller. Sequences the controller (one init request, then periodic burst reads), collects the 14-byte register burst it emits one byte per `data_avalid` strobe, and packs it into seven signed 16-bit words (accel X/Y/Z, temperature, gyro X/Y/Z) published atomically with a one-cycle `frame_valid`. Feeds the attitude-estimation stage.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SAMPLE_HZ`, 500, burst-read request rate.
- `TIMEOUT_CYC`, 200_000, max cycles from `mpu_transfer` to 14th byte before abort.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low. One clock, no other clock domains.
- `enable`  in  1  level; high runs init and sampling, low returns to IDLE after current frame/abort.
- `init_done`  in  1  level from controller.
- `busy_now`  in  1  level from controller.
- `data_avalid`  in  1  one-cycle strobe, byte valid on `data`.
- `data`  in  8  received byte.
- `mpu_init`  out  1  one-cycle init request to controller.
- `mpu_transfer`  out  1  one-cycle burst-read request.
- `ax`, `ay`, `az`, `temp`, `gx`, `gy`, `gz`  out  16 each  signed words, big-endian assembled.
- `frame_valid`  out  1  one-cycle pulse, all seven words updated.
- `frame_err`  out  1  one-cycle pulse on timeout abort.
- `tick_miss`  out  8  saturating count of sample ticks skipped.

## Operation
- States: IDLE, INIT_REQ, INIT_WAIT, ARMED, COLLECT.
- IDLE: `enable`=1 -> INIT_REQ if `init_done`=0, else ARMED.
- INIT_REQ: assert `mpu_init` one cycle (only when `busy_now`=0, else wait) -> INIT_WAIT.
- INIT_WAIT: `init_done`=1 -> ARMED. No timeout here; `enable`=0 -> IDLE.
- ARMED: on sample tick with `busy_now`=0 -> pulse `mpu_transfer`, clear byte index and timeout counter -> COLLECT. Tick with `busy_now`=1 -> stay, `tick_miss`+1 (saturate at 255). `enable`=0 -> IDLE.
- COLLECT: each `data_avalid` writes `data` to shadow byte [idx], idx+1. Byte 2k is MSB, 2k+1 LSB of word k; order ax, ay, az, temp, gx, gy, gz. At idx 13 strobe: copy shadow to outputs, `frame_valid` next cycle -> ARMED (or IDLE if `enable`=0). Timeout counter reaching `TIMEOUT_CYC` -> `frame_err`, outputs untouched, -> ARMED/IDLE.
- Sample tick in COLLECT: counted in `tick_miss`, not queued.
- `data_avalid` outside COLLECT ignored; shadow unchanged.
- `enable` dropping mid-COLLECT: frame completes or times out first.
- Reset: state IDLE, all outputs 0, `tick_miss`=0, shadow 0, tick divider 0.

## Timing
- Tick period = `CLK_HZ/SAMPLE_HZ` cycles (100_000 at defaults); divider free-runs whenever not IDLE.
- `mpu_transfer` asserted the cycle after the tick is sampled in ARMED.
- 14th `data_avalid` at cycle N -> output words change at N+1, `frame_valid` high at N+1 only.
- `frame_err` high for exactly the cycle following the timeout match.
- Requests and pulses never overlap; at most one `mpu_transfer` per frame.
- Words are two's-complement, no scaling or sign extension beyond 16 bits.

## Structure
- Package `mpu_pkg`: state enum, `MPU_BURST_BYTES`=14, word index constants (AX=0 … GZ=6).
- Sub-module `mpu_rate_tick`: parameterised divider, in `clk`/`rst_n`/`run`, out one-cycle `tick`.
- Shadow buffer: 14x8 register array inside `mpu_frame_asm`.

## Test plan
- Reset with `enable`=1, `init_done`=0 -> one `mpu_init` pulse; `init_done` raised -> first `mpu_transfer` after 100_000 cycles.
- Feed bytes 0x01..0x0E -> `ax`=0x0102, `az`=0x0506, `gz`=0x0D0E, single `frame_valid` one cycle after 14th strobe.
- Feed bytes with MSB 0xFF,0x38 for ax -> `ax`= -200 signed.
- Send only 9 bytes (`TIMEOUT_CYC`=1000 override) -> `frame_err` pulse at cycle 1001, previous words retained, next tick starts fresh frame.
- Hold `busy_now`=1 across 3 ticks -> no `mpu_transfer`, `tick_miss`=3; 300 ticks -> saturates at 255.
- Assert `rst_n`=0 mid-COLLECT at byte 7 -> all outputs 0 immediately, resumes from IDLE, no stale bytes in next frame.
